// File: rtl/uf7_sub_seq_pkg.sv
// Shared definitions for the uf7 simple-float datapath: field widths and subtractor FSM states.
// Pure declarations, no logic.
package uf7_sub_seq_pkg;

  localparam int UF7_EW = 3;
  localparam int UF7_MW = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMP   = 3'd1,
    ST_ALIGN = 3'd2,
    ST_SUB   = 3'd3,
    ST_NORM  = 3'd4,
    ST_RND   = 3'd5
  } state_t;

endpackage

// File: rtl/uf7_sub_seq_round.sv
// Round-half-up of a normalized {mant, guard} value to MW mantissa bits; carry flags mantissa overflow.
// Combinational, zero latency, no backpressure.
module uf7_sub_seq_round #(
  parameter int MW = 4
) (
  input  logic [MW:0]   diff,
  output logic [MW-1:0] mant,
  output logic          carry
);

  assign {carry, mant} = {1'b0, diff[MW:1]} + {{MW{1'b0}}, diff[0]};

endmodule

// File: rtl/uf7_sub_seq.sv
// Multi-cycle uf7 subtractor: |a-b| with neg/zero/uflow flags, one alignment shift per cycle.
// Latency 4+d+k cycles (2 when a==b); start is ignored while busy, results hold until the next start.
module uf7_sub_seq
  import uf7_sub_seq_pkg::*;
#(
  parameter int EW = UF7_EW,
  parameter int MW = UF7_MW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [EW+MW-1:0]  a,
  input  logic [EW+MW-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [EW+MW-1:0]  c,
  output logic              neg,
  output logic              zero,
  output logic              uflow
);

  localparam int W      = EW + MW;
  localparam int MANT_W = MW + 2;

  state_t state, state_n;

  logic [W-1:0]      a_r, a_n, b_r, b_n, big, sml, c_n;
  logic [MANT_W-1:0] m_l, m_l_n, m_s, m_s_n, diff, diff_n, sub_res;
  logic [EW-1:0]     exp_r, exp_n, cnt, cnt_n;
  logic              busy_n, done_n, neg_n, zero_n, uflow_n;
  logic [MW-1:0]     rnd_mant;
  logic              carry;

  // Whole-word compare orders the operands because the exponent sits in the MSBs.
  assign big     = (b_r > a_r) ? b_r : a_r;
  assign sml     = (b_r > a_r) ? a_r : b_r;
  assign sub_res = m_l - m_s;

  uf7_sub_seq_round #(.MW(MW)) u_round (
    .diff  (diff[MW:0]),
    .mant  (rnd_mant),
    .carry (carry)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      a_r   <= '0;
      b_r   <= '0;
      m_l   <= '0;
      m_s   <= '0;
      diff  <= '0;
      exp_r <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      c     <= '0;
      neg   <= 1'b0;
      zero  <= 1'b0;
      uflow <= 1'b0;
    end else begin
      state <= state_n;
      a_r   <= a_n;
      b_r   <= b_n;
      m_l   <= m_l_n;
      m_s   <= m_s_n;
      diff  <= diff_n;
      exp_r <= exp_n;
      cnt   <= cnt_n;
      busy  <= busy_n;
      done  <= done_n;
      c     <= c_n;
      neg   <= neg_n;
      zero  <= zero_n;
      uflow <= uflow_n;
    end
  end

  always_comb begin
    state_n = state;
    a_n     = a_r;
    b_n     = b_r;
    m_l_n   = m_l;
    m_s_n   = m_s;
    diff_n  = diff;
    exp_n   = exp_r;
    cnt_n   = cnt;
    busy_n  = busy;
    done_n  = 1'b0;
    c_n     = c;
    neg_n   = neg;
    zero_n  = zero;
    uflow_n = uflow;

    case (state)
      ST_IDLE: begin
        if (start) begin
          a_n     = a;
          b_n     = b;
          busy_n  = 1'b1;
          neg_n   = 1'b0;
          zero_n  = 1'b0;
          uflow_n = 1'b0;
          state_n = ST_CMP;
        end
      end
      ST_CMP: begin
        if (a_r == b_r) begin
          c_n     = '0;
          zero_n  = 1'b1;
          neg_n   = 1'b0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          neg_n   = (b_r > a_r);
          m_l_n   = {1'b1, big[MW-1:0], 1'b0};
          m_s_n   = {1'b1, sml[MW-1:0], 1'b0};
          exp_n   = big[W-1:MW];
          cnt_n   = big[W-1:MW] - sml[W-1:MW];
          state_n = (big[W-1:MW] == sml[W-1:MW]) ? ST_SUB : ST_ALIGN;
        end
      end
      ST_ALIGN: begin
        m_s_n = m_s >> 1;
        cnt_n = cnt - EW'(1);
        if (cnt == EW'(1))
          state_n = ST_SUB;
      end
      ST_SUB: begin
        diff_n  = sub_res;
        state_n = sub_res[MANT_W-1] ? ST_RND : ST_NORM;
      end
      ST_NORM: begin
        // Entered only with the MSB clear; an exhausted exponent means the result is unrepresentable.
        if (exp_r == '0) begin
          uflow_n = 1'b1;
          c_n     = '0;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_IDLE;
        end else begin
          diff_n = diff << 1;
          exp_n  = exp_r - EW'(1);
          if (diff[MANT_W-2])
            state_n = ST_RND;
        end
      end
      ST_RND: begin
        c_n     = {exp_r + EW'(carry), rnd_mant};
        done_n  = 1'b1;
        busy_n  = 1'b0;
        state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_uf7_sub_seq.sv
// Self-checking bench for uf7_sub_seq: directed vectors plus randomized operands against a value-level model.
module tb_uf7_sub_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [6:0] a, b, c;
  logic       busy, done, neg, zero, uflow;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  uf7_sub_seq dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .done  (done),
    .c     (c),
    .neg   (neg),
    .zero  (zero),
    .uflow (uflow)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: operands as integers scaled by 2^5 (hidden one, 4 mantissa bits, one guard bit).
  task automatic model(input logic [6:0] av, input logic [6:0] bv,
                       output logic [6:0] ec, output bit eneg, output bit ezero,
                       output bit euf, output int elat);
    int va, vb, el, es, ml, ms, d, df, k, q, e;
    ec = '0; eneg = 0; ezero = 0; euf = 0; elat = 2;
    va = (16 + int'(av[3:0])) << av[6:4];
    vb = (16 + int'(bv[3:0])) << bv[6:4];
    if (av == bv) begin
      ezero = 1;
      return;
    end
    eneg = (vb > va);
    if (eneg) begin
      el = int'(bv[6:4]); es = int'(av[6:4]);
      ml = 2 * (16 + int'(bv[3:0])); ms = 2 * (16 + int'(av[3:0]));
    end else begin
      el = int'(av[6:4]); es = int'(bv[6:4]);
      ml = 2 * (16 + int'(av[3:0])); ms = 2 * (16 + int'(bv[3:0]));
    end
    d  = el - es;
    ms = ms / (1 << d);
    df = ml - ms;
    k  = 0;
    while (df < 32) begin
      df = df * 2;
      k++;
    end
    if (k > el) begin
      euf  = 1;
      elat = 4 + d + el;
    end else begin
      e = el - k;
      q = (df + 1) / 2;
      if (q == 32) begin
        e++;
        q = 16;
      end
      ec   = {3'(e), 4'(q - 16)};
      elat = 4 + d + k;
    end
  endtask

  task automatic run_op(input logic [6:0] av, input logic [6:0] bv, input bit inject,
                        output logic [6:0] oc, output bit oneg, output bit ozero,
                        output bit ouf, output int olat);
    int n;
    bit got;
    oc = '0; oneg = 0; ozero = 0; ouf = 0; olat = -1;
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    n = 0; got = 0;
    while (!got && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 1) begin
        chk("busy_after_start", 32'(busy), 32'd1);
        start = inject;
        if (inject) begin
          a = 7'($urandom);
          b = 7'($urandom);
        end
      end else if (n == 3) begin
        start = 1'b0;
      end
      if (done) begin
        got   = 1;
        oc    = c;
        oneg  = neg;
        ozero = zero;
        ouf   = uflow;
        olat  = n;
        chk("busy_at_done", 32'(busy), 32'd0);
      end
    end
    start = 1'b0;
    if (!got) chk("done_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("c_hold", 32'(c), 32'(oc));
  endtask

  typedef struct {
    logic [6:0] a, b, c;
    bit         neg, zero, uf;
    int         lat;
  } vec_t;

  vec_t dir[6];

  task automatic check_against_model(input logic [6:0] av, input logic [6:0] bv, input bit inject);
    logic [6:0] gc, ec;
    bit gn, gz, gu, en, ez, eu;
    int gl, el;
    model(av, bv, ec, en, ez, eu, el);
    run_op(av, bv, inject, gc, gn, gz, gu, gl);
    chk("rand_c", 32'(gc), 32'(ec));
    chk("rand_neg", 32'(gn), 32'(en));
    chk("rand_zero", 32'(gz), 32'(ez));
    chk("rand_uflow", 32'(gu), 32'(eu));
    chk("rand_latency", 32'(gl), 32'(el));
  endtask

  initial begin
    logic [6:0] gc, ra, rb;
    bit gn, gz, gu;
    int gl;

    dir[0] = '{7'b1001000, 7'b1000000, 7'b0110000, 0, 0, 0, 5};
    dir[1] = '{7'b1000000, 7'b1001000, 7'b0110000, 1, 0, 0, 5};
    dir[2] = '{7'b1000101, 7'b1000101, 7'b0000000, 0, 1, 0, 2};
    dir[3] = '{7'b1010000, 7'b1000001, 7'b0111110, 0, 0, 0, 7};
    dir[4] = '{7'b1001111, 7'b0011111, 7'b1001100, 0, 0, 0, 7};
    dir[5] = '{7'b0000001, 7'b0000000, 7'b0000000, 0, 0, 1, 4};

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_c", 32'(c), 32'd0);
    chk("rst_neg", 32'(neg), 32'd0);
    chk("rst_zero", 32'(zero), 32'd0);
    chk("rst_uflow", 32'(uflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (dir[i]) begin
      run_op(dir[i].a, dir[i].b, 1'b0, gc, gn, gz, gu, gl);
      chk($sformatf("dir%0d_c", i), 32'(gc), 32'(dir[i].c));
      chk($sformatf("dir%0d_neg", i), 32'(gn), 32'(dir[i].neg));
      chk($sformatf("dir%0d_zero", i), 32'(gz), 32'(dir[i].zero));
      chk($sformatf("dir%0d_uflow", i), 32'(gu), 32'(dir[i].uf));
      chk($sformatf("dir%0d_latency", i), 32'(gl), 32'(dir[i].lat));
    end

    // A second start while busy must not disturb the first operation.
    run_op(dir[3].a, dir[3].b, 1'b1, gc, gn, gz, gu, gl);
    chk("busy_start_c", 32'(gc), 32'(dir[3].c));
    chk("busy_start_latency", 32'(gl), 32'(dir[3].lat));

    // Asynchronous reset in the middle of a 7-step alignment.
    @(negedge clk);
    a = 7'b0000000; b = 7'b1110000; start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_c", 32'(c), 32'd0);
    chk("mid_rst_neg", 32'(neg), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_zero", 32'(zero), 32'd0);
    chk("mid_rst_uflow", 32'(uflow), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    check_against_model(7'b1010000, 7'b1000001, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ra = 7'($urandom);
      case ($urandom_range(0, 3))
        0:       rb = ra;
        1:       rb = {ra[6:4], 4'($urandom)};
        default: rb = 7'($urandom);
      endcase
      check_against_model(ra, rb, ($urandom_range(0, 3) == 0) && (ra != rb));
    end

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

endmodule
